expr_vector_sequencer: RTL and testbench



---
 rtl/expr_vector_sequencer.sv | 112 +++++++++++
 tb/tb_expr_vector_sequencer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/expr_vector_sequencer.sv
// Drives vectors into a combinational DUT, folds each result into a 32-bit MISR and compares the final signature with a golden value.
// Each vector takes LAT+2 cycles, and the compare adds one more. stall freezes every register.
module expr_vector_sequencer #(
  parameter int          IN_W    = 72,
  parameter int          OUT_W   = 90,
  parameter int          NUM_VEC = 256,
  parameter int          LAT     = 0,
  parameter logic [31:0] SEED    = 32'h1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       stall,
  input  logic [31:0]                golden_sig,
  output logic [IN_W-1:0]            dut_in,
  input  logic [OUT_W-1:0]           dut_out,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [31:0]                sig,
  output logic [$clog2(NUM_VEC):0]   vec_cnt
);
  localparam int CNT_W = $clog2(NUM_VEC) + 1;
  localparam int NCH   = (OUT_W + 31) / 32;
  localparam int LAT_W = 4;

  typedef enum logic [2:0] {IDLE, DRIVE, WAIT, CAPT, CMP, DONE} state_t;

  state_t             state, state_nxt;
  logic [31:0]        lfsr;
  logic [31:0]        lfsr_step;
  logic [LAT_W-1:0]   wait_cnt;
  logic [NCH*32-1:0]  out_pad;
  logic [31:0]        fold;
  logic [31:0]        misr_nxt;
  logic [IN_W-1:0]    vec_nxt;
  logic [CNT_W-1:0]   cnt_inc;

  assign busy      = (state == DRIVE) || (state == WAIT) || (state == CAPT) || (state == CMP);
  assign done      = (state == DONE);
  assign cnt_inc   = vec_cnt + 1'b1;
  assign lfsr_step = (lfsr >> 1) ^ (lfsr[0] ? 32'h80200003 : 32'h0);
  assign misr_nxt  = {sig[30:0], 1'b0} ^ (sig[31] ? 32'h04C11DB7 : 32'h0) ^ fold;

  // Top chunk of dut_out is zero-padded up to a full 32-bit word before folding.
  always_comb begin
    out_pad = '0;
    out_pad[OUT_W-1:0] = dut_out;
    fold = '0;
    for (int i = 0; i < NCH; i++) begin
      fold = fold ^ out_pad[i*32 +: 32];
    end
  end

  always_comb begin
    vec_nxt = IN_W'({lfsr ^ 32'hA5A5A5A5, ~lfsr, lfsr});
    if (vec_cnt == '0) begin
      vec_nxt = '0;
    end else if (vec_cnt == CNT_W'(1)) begin
      vec_nxt = '1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = DRIVE;
      DRIVE:      state_nxt = (LAT > 0) ? WAIT : CAPT;
      WAIT:       if (wait_cnt == LAT_W'(LAT - 1)) state_nxt = CAPT;
      CAPT:       state_nxt = (cnt_inc == CNT_W'(NUM_VEC)) ? CMP : DRIVE;
      CMP:        state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      dut_in   <= '0;
      pass     <= 1'b0;
      sig      <= '0;
      vec_cnt  <= '0;
      lfsr     <= SEED;
      wait_cnt <= '0;
    end else if (!stall) begin
      state <= state_nxt;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            sig     <= '0;
            vec_cnt <= '0;
            pass    <= 1'b0;
            lfsr    <= SEED;
          end
        end
        DRIVE: begin
          dut_in   <= vec_nxt;
          wait_cnt <= '0;
          // The first two vectors are fixed patterns and do not consume LFSR states.
          if (vec_cnt >= CNT_W'(2)) lfsr <= lfsr_step;
        end
        WAIT: wait_cnt <= wait_cnt + 1'b1;
        CAPT: begin
          sig     <= misr_nxt;
          vec_cnt <= cnt_inc;
        end
        CMP:     pass <= (sig == golden_sig);
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_expr_vector_sequencer.sv
// Bench for expr_vector_sequencer. It runs three instances: 4 vectors with LAT=0, 2 vectors with a constant result, and 8 vectors with LAT=3 in front of a delayed DUT.
module tb_expr_vector_sequencer;
  localparam logic [31:0] POLY = 32'h04C11DB7;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Instance A: NUM_VEC=4, LAT=0, combinational keyed DUT or constant zero
  logic        start_a = 0, zero_a = 1;
  logic [31:0] golden_a = 0;
  logic [89:0] key_a = '0;
  logic [71:0] dut_in_a;
  logic [89:0] dut_out_a;
  logic        busy_a, done_a, pass_a;
  logic [31:0] sig_a;
  logic [2:0]  vec_cnt_a;

  // Instance B: NUM_VEC=2, LAT=0, DUT result tied to 1
  logic        start_b = 0;
  logic [31:0] golden_b = 0;
  logic [71:0] dut_in_b;
  logic        busy_b, done_b, pass_b;
  logic [31:0] sig_b;
  logic [1:0]  vec_cnt_b;

  // Instance C: NUM_VEC=8, LAT=3, DUT modelled with a 3-cycle pipeline
  logic        start_c = 0, stall_c = 0;
  logic [31:0] golden_c = 0;
  logic [89:0] key_c = '0;
  logic [71:0] dut_in_c;
  logic [89:0] pipe1, pipe2, pipe3;
  logic        busy_c, done_c, pass_c;
  logic [31:0] sig_c;
  logic [3:0]  vec_cnt_c;

  function automatic logic [89:0] expr_f(input logic [71:0] x, input logic [89:0] key);
    return key ^ {x[17:0], x};
  endfunction

  assign dut_out_a = zero_a ? 90'd0 : expr_f(dut_in_a, key_a);

  always @(posedge clk) begin
    pipe1 <= expr_f(dut_in_c, key_c);
    pipe2 <= pipe1;
    pipe3 <= pipe2;
  end

  expr_vector_sequencer #(.IN_W(72), .OUT_W(90), .NUM_VEC(4), .LAT(0), .SEED(32'h1)) u_a (
    .clk(clk), .reset(reset), .start(start_a), .stall(1'b0), .golden_sig(golden_a),
    .dut_in(dut_in_a), .dut_out(dut_out_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .sig(sig_a), .vec_cnt(vec_cnt_a));

  expr_vector_sequencer #(.IN_W(72), .OUT_W(90), .NUM_VEC(2), .LAT(0), .SEED(32'h1)) u_b (
    .clk(clk), .reset(reset), .start(start_b), .stall(1'b0), .golden_sig(golden_b),
    .dut_in(dut_in_b), .dut_out(90'd1), .busy(busy_b), .done(done_b), .pass(pass_b),
    .sig(sig_b), .vec_cnt(vec_cnt_b));

  expr_vector_sequencer #(.IN_W(72), .OUT_W(90), .NUM_VEC(8), .LAT(3), .SEED(32'h1)) u_c (
    .clk(clk), .reset(reset), .start(start_c), .stall(stall_c), .golden_sig(golden_c),
    .dut_in(dut_in_c), .dut_out(pipe3), .busy(busy_c), .done(done_c), .pass(pass_c),
    .sig(sig_c), .vec_cnt(vec_cnt_c));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: the vector list, then the MISR over the folded results.
  function automatic logic [71:0] model_vec(input int k);
    logic [31:0] l;
    logic [95:0] w;
    l = 32'h1;
    if (k == 0) return '0;
    if (k == 1) return '1;
    for (int i = 2; i < k; i++) l = (l >> 1) ^ (l[0] ? 32'h80200003 : 32'h0);
    w = {l ^ 32'hA5A5A5A5, ~l, l};
    return w[71:0];
  endfunction

  function automatic logic [31:0] model_sig(input int n, input logic [89:0] key, input bit zero);
    logic [31:0] s, f;
    logic [89:0] o;
    s = '0;
    for (int k = 0; k < n; k++) begin
      o = zero ? 90'd0 : expr_f(model_vec(k), key);
      f = o[31:0] ^ o[63:32] ^ {6'd0, o[89:64]};
      s = {s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0) ^ f;
    end
    return s;
  endfunction

  logic [71:0] vecs_a[$];

  task automatic run_a(input bit zero, input logic [31:0] gold, input bit mid_start, output int nbusy);
    int guard;
    zero_a = zero;
    golden_a = gold;
    vecs_a.delete();
    start_a = 1;
    @(negedge clk);
    start_a = 0;
    chk("a_busy_after_start", busy_a, 1);
    chk("a_done_drops", done_a, 0);
    nbusy = 0;
    guard = 0;
    while (!done_a && guard < 200) begin
      if (busy_a) nbusy++;
      if (busy_a && nbusy % 2 == 0 && nbusy <= 8) vecs_a.push_back(dut_in_a);
      start_a = mid_start && (nbusy == 3);
      @(negedge clk);
      guard++;
    end
    start_a = 0;
    chk("a_timeout", guard < 200, 1);
  endtask

  task automatic run_c(input logic [31:0] gold, input int stall_at, input int reset_at, output int nbusy);
    int guard;
    bit stalled;
    logic [127:0] snap;
    golden_c = gold;
    start_c = 1;
    @(negedge clk);
    start_c = 0;
    nbusy = 0;
    guard = 0;
    stalled = 0;
    while (!done_c && guard < 500) begin
      if (busy_c) nbusy++;
      if (nbusy == reset_at) begin
        reset = 1;
        @(negedge clk);
        reset = 0;
        chk("rst_busy", busy_c, 0);
        chk("rst_done", done_c, 0);
        chk("rst_pass", pass_c, 0);
        chk("rst_sig", sig_c, 0);
        chk("rst_vec_cnt", vec_cnt_c, 0);
        chk("rst_dut_in", dut_in_c, 0);
        return;
      end
      if (nbusy == stall_at && !stalled) begin
        stalled = 1;
        snap = {dut_in_c, sig_c, vec_cnt_c, busy_c, done_c, pass_c};
        stall_c = 1;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          if (busy_c) nbusy++;
          chk("stall_hold", {dut_in_c, sig_c, vec_cnt_c, busy_c, done_c, pass_c}, snap);
        end
        stall_c = 0;
      end
      @(negedge clk);
      guard++;
    end
    chk("c_timeout", guard < 500, 1);
  endtask

  initial begin
    int nb, guard;
    logic [31:0] exp, gold;
    logic [71:0] v2;

    repeat (3) @(negedge clk);
    reset = 0;
    chk("reset_dut_in", dut_in_a, 0);
    chk("reset_busy", busy_a, 0);
    chk("reset_done", done_a, 0);
    chk("reset_pass", pass_a, 0);
    chk("reset_sig", sig_a, 0);
    chk("reset_vec_cnt", vec_cnt_a, 0);

    // A: zero DUT result, golden 0
    run_a(1, 32'h0, 0, nb);
    chk("a0_busy_cycles", nb, 9);
    chk("a0_done", done_a, 1);
    chk("a0_sig", sig_a, 32'h0);
    chk("a0_vec_cnt", vec_cnt_a, 4);
    chk("a0_pass", pass_a, 1);
    chk("a0_nvec", vecs_a.size(), 4);
    chk("vec0_zero", vecs_a[0], 72'h0);
    chk("vec1_ones", vecs_a[1], {72{1'b1}});
    v2 = vecs_a[2];
    chk("vec2_low", v2[31:0], 32'h00000001);
    chk("vec2_mid", v2[63:32], 32'hFFFFFFFE);
    chk("vec2_top", v2[71:64], 8'hA4);
    chk("vec3_model", vecs_a[3], model_vec(3));
    repeat (3) @(negedge clk);
    chk("a0_done_held", done_a, 1);
    chk("a0_sig_held", sig_a, 32'h0);

    // A: randomized DUT keys, golden right or wrong, with a start pulse mid-run that must be ignored
    for (int r = 0; r < 4; r++) begin
      key_a = {$urandom, $urandom, $urandom};
      exp = model_sig(4, key_a, 0);
      gold = $urandom_range(0, 1) ? exp : exp ^ (32'h1 << $urandom_range(0, 31));
      run_a(0, gold, 1, nb);
      chk("ar_busy_cycles", nb, 9);
      chk("ar_sig", sig_a, exp);
      chk("ar_pass", pass_a, gold == exp);
    end

    // B: constant result 1, golden 3 then 2
    for (int r = 0; r < 2; r++) begin
      golden_b = (r == 0) ? 32'h3 : 32'h2;
      start_b = 1;
      @(negedge clk);
      start_b = 0;
      nb = 0;
      guard = 0;
      while (!done_b && guard < 100) begin
        if (busy_b) nb++;
        if (nb == 3) chk("b_sig_vec0", sig_b, 32'h1);
        @(negedge clk);
        guard++;
      end
      chk("b_busy_cycles", nb, 5);
      chk("b_sig", sig_b, 32'h3);
      chk("b_vec_cnt", vec_cnt_b, 2);
      chk("b_pass", pass_b, r == 0);
      chk("b_last_dut_in", dut_in_b, {72{1'b1}});
    end

    // C: LAT=3 against the delayed DUT must match the combinational model signature
    key_c = {$urandom, $urandom, $urandom};
    exp = model_sig(8, key_c, 0);
    run_c(exp, -1, -1, nb);
    chk("c_busy_cycles", nb, 41);
    chk("c_sig", sig_c, exp);
    chk("c_pass", pass_c, 1);
    chk("c_vec_cnt", vec_cnt_c, 8);

    // C: start together with stall is dropped
    start_c = 1;
    stall_c = 1;
    @(negedge clk);
    start_c = 0;
    stall_c = 0;
    @(negedge clk);
    chk("c_stall_start_busy", busy_c, 0);
    chk("c_stall_start_done", done_c, 1);

    // C: 5-cycle stall mid-run
    run_c(exp ^ 32'h1, 12, -1, nb);
    chk("cs_busy_cycles", nb, 46);
    chk("cs_sig", sig_c, exp);
    chk("cs_pass", pass_c, 0);

    // C: reset while in WAIT, then a fresh run
    run_c(exp, -1, 8, nb);
    @(negedge clk);
    chk("c_idle_after_reset", {busy_c, done_c}, 2'b00);
    key_c = {$urandom, $urandom, $urandom};
    exp = model_sig(8, key_c, 0);
    run_c(exp, -1, -1, nb);
    chk("cf_busy_cycles", nb, 41);
    chk("cf_sig", sig_c, exp);
    chk("cf_pass", pass_c, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
